wrr_slice_arbiter: RTL and testbench

Four-requester round-robin arbiter with a per-requester programmable time slice (quantum), registered one-hot grant, and slice-boundary rotation. It shares a single downstream resource, such as a bus port or shared engine, among four masters. Software or a config master sets each requester's quantum at run time. An optional starvation monitor flags requesters that wait too long.

---
 rtl/wrr_slice_arbiter.sv | 137 +++++++++++++
 tb/tb_wrr_slice_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wrr_slice_arbiter.sv
// Four-requester round-robin arbiter with per-requester programmable quanta and registered one-hot grant.
// Define WRR_SLICE_ARB_STARVE_MON_EN to build the per-requester starvation monitor.
module wrr_slice_arbiter #(
    parameter int QW         = 4,
    parameter int STARVE_LIM = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_sel,
    input  logic [QW-1:0] cfg_quantum,
    output logic [3:0]    gnt,
    output logic [1:0]    gnt_id,
    output logic          gnt_valid,
    output logic          slice_end,
    output logic [3:0]    starve
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [QW-1:0] quanta [4];
    logic [QW-1:0] cnt;
    logic [QW-1:0] q_act;
    logic [1:0]    last;
    logic [1:0]    pick;
    logic          expiry;

    function automatic logic [1:0] next_after(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] sel;
        logic [1:0] idx;
        logic       found;
        sel   = from;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = from + 2'(i);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // last always tracks the holder while granting, so one scan serves both states
    assign pick   = next_after(req, last);
    assign expiry = (cnt == (q_act - 1'b1));

    // Decoded from registered slice state only, so it carries no path from req
    assign slice_end = (state == GRANT) && expiry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            cnt       <= '0;
            q_act     <= QW'(4);
            last      <= 2'd3;
            for (int i = 0; i < 4; i++) begin
                quanta[i] <= QW'(4);
            end
        end else begin
            if (cfg_we) begin
                quanta[cfg_sel] <= (cfg_quantum == '0) ? QW'(1) : cfg_quantum;
            end
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << pick;
                        gnt_id    <= pick;
                        gnt_valid <= 1'b1;
                        last      <= pick;
                        cnt       <= '0;
                        q_act     <= quanta[pick];
                    end
                end
                GRANT: begin
                    // A lone holder at expiry re-picks itself and simply relatches its quantum
                    if (!req[gnt_id] || expiry) begin
                        if (|req) begin
                            gnt       <= 4'b0001 << pick;
                            gnt_id    <= pick;
                            gnt_valid <= 1'b1;
                            last      <= pick;
                            cnt       <= '0;
                            q_act     <= quanta[pick];
                        end else begin
                            state     <= IDLE;
                            gnt       <= 4'b0000;
                            gnt_valid <= 1'b0;
                            cnt       <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WRR_SLICE_ARB_STARVE_MON_EN
    logic [7:0] wait_cnt [4];
    logic [7:0] wait_nxt [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wait_nxt[i] = 8'd0;
            if (req[i] && !gnt[i]) begin
                wait_nxt[i] = (wait_cnt[i] == 8'hFF) ? 8'hFF : wait_cnt[i] + 8'd1;
            end
        end
    end

    // starve follows the counter value being stored on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                wait_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                wait_cnt[i] <= wait_nxt[i];
                starve[i]   <= (wait_nxt[i] >= 8'(STARVE_LIM));
            end
        end
    end
`else
    assign starve = 4'b0000;
`endif

endmodule

// File: tb/tb_wrr_slice_arbiter.sv
// Randomized self-checking bench for wrr_slice_arbiter against a slice-level reference model.
module tb_wrr_slice_arbiter;

    localparam int QW         = 4;
    localparam int STARVE_LIM = 8;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [QW-1:0] cfg_quantum;
    logic [3:0]    gnt;
    logic [1:0]    gnt_id;
    logic          gnt_valid;
    logic          slice_end;
    logic [3:0]    starve;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    // Reference model: who holds the resource, how long it has held it in this slice
    int holder;
    int served;
    int slice_len;
    int last_served;
    int quanta [4];
    int waited [4];

    wrr_slice_arbiter #(.QW(QW), .STARVE_LIM(STARVE_LIM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_quantum (cfg_quantum),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .gnt_valid   (gnt_valid),
        .slice_end   (slice_end),
        .starve      (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    function automatic int next_requester(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        holder      = -1;
        served      = 0;
        slice_len   = 4;
        last_served = 3;
        for (int i = 0; i < 4; i++) begin
            quanta[i] = 4;
            waited[i] = 0;
        end
    endtask

    task automatic model_grant(input int who);
        holder      = who;
        last_served = who;
        served      = 0;
        slice_len   = quanta[who];
    endtask

    task automatic model_step(input logic [3:0] r, input logic we, input logic [1:0] sel, input int q);
        for (int i = 0; i < 4; i++) begin
            if (r[i] && holder != i) waited[i] = (waited[i] < 255) ? waited[i] + 1 : 255;
            else                     waited[i] = 0;
        end
        if (holder < 0) begin
            if (r != 4'b0000) model_grant(next_requester(r, last_served));
        end else if (!r[holder] || served + 1 == slice_len) begin
            if (r == 4'b0000) holder = -1;
            else              model_grant(next_requester(r, holder));
        end else begin
            served++;
        end
        if (we) quanta[sel] = (q == 0) ? 1 : q;
    endtask

    task automatic compare_outputs();
        logic [3:0] exp_gnt;
        logic [3:0] exp_starve;
        bit         at_expiry;
        exp_gnt    = (holder < 0) ? 4'b0000 : 4'(1 << holder);
        exp_starve = 4'b0000;
`ifdef WRR_SLICE_ARB_STARVE_MON_EN
        for (int i = 0; i < 4; i++) exp_starve[i] = (waited[i] >= STARVE_LIM);
`endif
        at_expiry = (holder >= 0) && (served + 1 == slice_len);
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("gnt_valid", 32'(gnt_valid), 32'(holder >= 0));
        if (holder >= 0) checkOutput("gnt_id", 32'(gnt_id), 32'(holder));
        // A release coinciding with expiry is left unchecked for slice_end
        if (!(at_expiry && !req[holder])) checkOutput("slice_end", 32'(slice_end), 32'(at_expiry));
        checkOutput("starve", 32'(starve), 32'(exp_starve));
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic we, input logic [1:0] sel, input int q);
        @(negedge clk);
        compare_outputs();
        req         = r;
        cfg_we      = we;
        cfg_sel     = sel;
        cfg_quantum = QW'(q);
        @(posedge clk);
        model_step(r, we, sel, q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        req    = 4'b0000;
        cfg_we = 1'b0;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_valid", 32'(gnt_valid), 32'h0);
        checkOutput("rst_slice_end", 32'(slice_end), 32'h0);
        checkOutput("rst_starve", 32'(starve), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n       = 1'b0;
        req         = 4'b0000;
        cfg_we      = 1'b0;
        cfg_sel     = 2'd0;
        cfg_quantum = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        checkOutput("reset_gnt_id", 32'(gnt_id), 32'h0);
        rst_n = 1'b1;

        // Single requester, then full contention with default quanta
        for (int i = 0; i < 10; i++) applyStimulus(4'b0001, 1'b0, 2'd0, 0);
        for (int i = 0; i < 36; i++) applyStimulus(4'b1111, 1'b0, 2'd0, 0);

        // Programmed quanta: Q1=2, Q0=0 stored as 1
        applyStimulus(4'b0000, 1'b1, 2'd1, 2);
        applyStimulus(4'b0000, 1'b1, 2'd0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(4'b0011, 1'b0, 2'd0, 0);

        // Early release, mid-slice quantum write, then reset mid-grant
        do_reset();
        applyStimulus(4'b0101, 1'b0, 2'd0, 0);
        applyStimulus(4'b0101, 1'b0, 2'd0, 0);
        applyStimulus(4'b0100, 1'b0, 2'd0, 0);
        applyStimulus(4'b0000, 1'b0, 2'd0, 0);
        applyStimulus(4'b0001, 1'b0, 2'd0, 0);
        applyStimulus(4'b0011, 1'b1, 2'd0, 7);
        for (int i = 0; i < 20; i++) applyStimulus(4'b0011, 1'b0, 2'd0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 1'b0, 2'd0, 0);

        // Starvation: long quantum on requester 0 keeps requester 1 waiting
        applyStimulus(4'b0000, 1'b1, 2'd0, 15);
        for (int i = 0; i < 40; i++) applyStimulus(4'b0011, 1'b0, 2'd0, 0);

        // Randomized traffic with sporadic quantum writes and resets
        r = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 9) == 0)
                applyStimulus(r, 1'b1, 2'($urandom_range(0, 3)),
                              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5)));
            else
                applyStimulus(r, 1'b0, 2'd0, 0);
            if (i % 500 == 499) begin
                do_reset();
                r = 4'b0000;
            end
        end
        @(negedge clk);
        compare_outputs();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
